// File: rtl/counter_sequencer.sv
// Command-driven sequencer for an external up/down/load/clear counter.
// Accepts CLEAR/LOAD/UP N/DOWN N over valid/ready and reports completion with a done pulse.
module counter_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic             abort,
  input  logic [WIDTH-1:0] ctr_out,
  output logic [WIDTH-1:0] ctr_datain,
  output logic             ctr_clear,
  output logic             ctr_load,
  output logic             ctr_counten,
  output logic             ctr_inc,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] done_value,
  output logic             done_wrap,
  output logic             done_abort
);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_LD, S_RUN, S_DONE} state_t;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_UP    = 2'b10;

  state_t           state, state_n;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] arg_q;
  logic [WIDTH-1:0] remaining;
  logic             wrap_q, abort_q;
  logic [WIDTH-1:0] hold_value;
  logic             hold_wrap, hold_abort;

  always_comb begin
    state_n     = state;
    cmd_ready   = 1'b0;
    ctr_clear   = 1'b0;
    ctr_load    = 1'b0;
    ctr_counten = 1'b0;
    ctr_inc     = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy      = 1'b0;
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_op == OP_CLEAR)     state_n = S_CLR;
          else if (cmd_op == OP_LOAD) state_n = S_LD;
          else if (cmd_arg == '0)     state_n = S_DONE;
          else                        state_n = S_RUN;
        end
      end
      S_CLR: begin
        ctr_clear = 1'b1;
        state_n   = S_DONE;
      end
      S_LD: begin
        ctr_load = 1'b1;
        state_n  = S_DONE;
      end
      S_RUN: begin
        ctr_counten = 1'b1;
        ctr_inc     = (op_q == OP_UP);
        if (abort || remaining == WIDTH'(1)) state_n = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      op_q       <= '0;
      arg_q      <= '0;
      remaining  <= '0;
      wrap_q     <= 1'b0;
      abort_q    <= 1'b0;
      hold_value <= '0;
      hold_wrap  <= 1'b0;
      hold_abort <= 1'b0;
    end else begin
      state <= state_n;
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q      <= cmd_op;
            arg_q     <= cmd_arg;
            remaining <= cmd_arg;
            wrap_q    <= 1'b0;
            abort_q   <= 1'b0;
          end
        end
        S_RUN: begin
          remaining <= remaining - WIDTH'(1);
          if ((ctr_inc && ctr_out == '1) || (!ctr_inc && ctr_out == '0)) wrap_q <= 1'b1;
          if (abort) abort_q <= 1'b1;
        end
        S_DONE: begin
          hold_value <= ctr_out;
          hold_wrap  <= wrap_q;
          hold_abort <= abort_q;
        end
        default: ;
      endcase
    end
  end

  // The counter's final step lands on the edge entering DONE, so the live
  // ctr_out is reported during DONE and captured for holding on exit.
  assign done_value = (state == S_DONE) ? ctr_out : hold_value;
  assign done_wrap  = (state == S_DONE) ? wrap_q  : hold_wrap;
  assign done_abort = (state == S_DONE) ? abort_q : hold_abort;
  assign ctr_datain = arg_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer: models the external counter and
// predicts each command's outcome from its arithmetic effect on the count.
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_arg = 8'h00;
  logic       abort = 1'b0;
  logic [7:0] ctr_out;
  logic [7:0] ctr_datain;
  logic       ctr_clear, ctr_load, ctr_counten, ctr_inc;
  logic       busy, done, done_wrap, done_abort;
  logic [7:0] done_value;

  int total = 0;
  int bad = 0;
  int ref_val = 0;

  counter_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .abort(abort), .ctr_out(ctr_out),
    .ctr_datain(ctr_datain), .ctr_clear(ctr_clear), .ctr_load(ctr_load),
    .ctr_counten(ctr_counten), .ctr_inc(ctr_inc), .busy(busy), .done(done),
    .done_value(done_value), .done_wrap(done_wrap), .done_abort(done_abort)
  );

  always #5 clk = ~clk;

  // External counter, never reset, registered output
  logic [7:0] ctr_q = 8'h33;
  always @(posedge clk) begin
    if (ctr_clear)        ctr_q <= 8'h00;
    else if (ctr_load)    ctr_q <= ctr_datain;
    else if (ctr_counten) ctr_q <= ctr_inc ? ctr_q + 8'd1 : ctr_q - 8'd1;
  end
  assign ctr_out = ctr_q;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Called just after a negedge with the DUT in IDLE; returns just after a negedge in IDLE.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] arg,
                         input int abort_at, input bit hold, input string name);
    int steps, t, exp_lat, lat, n_cnt, n_clr, n_ld, viol;
    logic [7:0] exp_v;
    bit exp_w, exp_a, seen;
    steps = 0; exp_a = 0; exp_w = 0;
    if (op == 2'b00) exp_v = 8'h00;
    else if (op == 2'b01) exp_v = arg;
    else begin
      steps = int'(arg);
      if (abort_at > 0 && abort_at <= int'(arg)) begin
        steps = abort_at;
        exp_a = 1;
      end
      if (op == 2'b10) begin
        t = ref_val + steps;
        exp_w = (t > 255);
      end else begin
        t = ref_val - steps;
        exp_w = (t < 0);
      end
      exp_v = 8'((t + 256) % 256);
    end
    exp_lat = (op[1] == 1'b0) ? 2 : steps + 1;

    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s ready_at_issue: got %b want 1", name, cmd_ready);
    end
    cmd_op = op; cmd_arg = arg; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;

    lat = 0; n_cnt = 0; n_clr = 0; n_ld = 0; viol = 0; seen = 0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      if (ctr_counten) n_cnt++;
      if (ctr_clear) n_clr++;
      if (ctr_load) n_ld++;
      if (int'(ctr_clear) + int'(ctr_load) + int'(ctr_counten) > 1) viol++;
      if (ctr_counten && ctr_inc !== (op == 2'b10)) viol++;
      if (cmd_ready || !busy) viol++;
      if (done) begin
        lat = cyc;
        seen = 1;
        break;
      end
      abort = (cyc == abort_at);
      @(negedge clk);
    end
    abort = 1'b0;

    total++;
    if (!seen || lat != exp_lat) begin
      bad++;
      $display("FAIL %s done_latency: got %0d (seen=%0d) want %0d", name, lat, seen, exp_lat);
    end
    total++;
    if (n_cnt != steps) begin
      bad++;
      $display("FAIL %s counten_cycles: got %0d want %0d", name, n_cnt, steps);
    end
    total++;
    if (n_clr != int'(op == 2'b00) || n_ld != int'(op == 2'b01)) begin
      bad++;
      $display("FAIL %s clear_load_cycles: got clr=%0d ld=%0d want %0d/%0d",
               name, n_clr, n_ld, int'(op == 2'b00), int'(op == 2'b01));
    end
    total++;
    if (viol != 0) begin
      bad++;
      $display("FAIL %s pin_rules: got %0d violations want 0", name, viol);
    end
    total++;
    if (done_value !== exp_v || done_wrap !== exp_w || done_abort !== exp_a) begin
      bad++;
      $display("FAIL %s done_result: got v=%h w=%b a=%b want v=%h w=%b a=%b",
               name, done_value, done_wrap, done_abort, exp_v, exp_w, exp_a);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || done_value !== exp_v || done_wrap !== exp_w || done_abort !== exp_a) begin
      bad++;
      $display("FAIL %s held_after_done: got done=%b v=%h w=%b a=%b want 0 %h %b %b",
               name, done, done_value, done_wrap, done_abort, exp_v, exp_w, exp_a);
    end
    ref_val = int'(exp_v);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({ctr_clear, ctr_load, ctr_counten, ctr_inc, busy, done, done_wrap, done_abort} !== 8'h00 ||
        done_value !== 8'h00 || ctr_datain !== 8'h00 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: got clr=%b ld=%b en=%b inc=%b busy=%b done=%b v=%h w=%b a=%b din=%h rdy=%b want all 0, rdy=1",
               ctr_clear, ctr_load, ctr_counten, ctr_inc, busy, done, done_value,
               done_wrap, done_abort, ctr_datain, cmd_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_clear();
    run_cmd(2'b00, 8'h5C, 0, 0, "clear");
  endtask

  task automatic test_load_up();
    run_cmd(2'b01, 8'hA5, 0, 0, "load_a5");
    run_cmd(2'b10, 8'd3, 0, 0, "up3");
  endtask

  task automatic test_wrap();
    run_cmd(2'b01, 8'hFE, 0, 0, "load_fe");
    run_cmd(2'b10, 8'd4, 0, 0, "up4_wrap");
    run_cmd(2'b01, 8'h01, 0, 0, "load_01");
    run_cmd(2'b11, 8'd3, 0, 0, "down3_wrap");
    run_cmd(2'b01, 8'hFF, 0, 0, "load_ff");
    run_cmd(2'b11, 8'd1, 0, 0, "down1_nowrap");
  endtask

  task automatic test_zero_hold();
    run_cmd(2'b01, 8'h10, 0, 0, "load_10");
    run_cmd(2'b10, 8'd0, 0, 1, "up0_held_valid");
    run_cmd(2'b11, 8'd0, 0, 0, "down0_next");
  endtask

  task automatic test_abort();
    run_cmd(2'b01, 8'h00, 0, 0, "load_00");
    run_cmd(2'b10, 8'd200, 5, 0, "up200_abort5");
    run_cmd(2'b11, 8'd3, 3, 0, "down3_abort_last");
    run_cmd(2'b10, 8'd4, 9, 0, "up4_abort_late");
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [7:0] arg;
    int ab;
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      if (op == 2'b01) arg = 8'($urandom_range(0, 255));
      else if ($urandom_range(0, 7) == 0) arg = 8'($urandom_range(0, 255));
      else arg = 8'($urandom_range(0, 12));
      ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 14)) : 0;
      run_cmd(op, arg, ab, 1'($urandom_range(0, 1)) & (op != 2'b00), $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_reset_mid_run();
    int spurious;
    run_cmd(2'b01, 8'h20, 0, 0, "load_20");
    cmd_op = 2'b10; cmd_arg = 8'd50; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (ctr_counten !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_run_async: got en=%b busy=%b done=%b want 0 0 0", ctr_counten, busy, done);
    end
    spurious = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) spurious++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) spurious++;
    end
    total++;
    if (spurious != 0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_run_after: got done_pulses=%0d rdy=%b want 0 1", spurious, cmd_ready);
    end
    run_cmd(2'b01, 8'h7F, 0, 0, "load_after_reset");
    run_cmd(2'b10, 8'd2, 0, 0, "up2_after_reset");
  endtask

  initial begin
    test_reset();
    test_clear();
    test_load_up();
    test_wrap();
    test_zero_hold();
    test_abort();
    test_random();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
